// File: rtl/idx_to_vec.sv
// Streaming index-to-vector assembler: rebuilds a bit vector from a stream of set-bit indices.
// Latency: vector valid the cycle after the last beat; held registered until vec_ready_i.
// Backpressure: no beats accepted while a vector is held, unless IDX_TO_VEC_OVERLAP_EN is defined.
module idx_to_vec #(
    parameter int   WIDTH = 32,
    parameter logic MODE  = 1'b0,
    parameter int   IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [IDX_W-1:0]           idx_i,
    input  logic                       idx_empty_i,
    input  logic                       idx_last_i,
    input  logic                       idx_valid_i,
    output logic                       idx_ready_o,
    output logic [WIDTH-1:0]           vec_o,
    output logic [$clog2(WIDTH+1)-1:0] cnt_o,
    output logic                       dup_o,
    output logic                       oor_o,
    output logic                       vec_valid_o,
    input  logic                       vec_ready_i
);

    localparam int               CW    = $clog2(WIDTH + 1);
    localparam logic [IDX_W:0]   LIMIT = (IDX_W + 1)'(WIDTH);
    localparam logic [IDX_W-1:0] TOP   = IDX_W'(WIDTH - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] acc, acc_n, base_acc, onehot;
    logic [CW-1:0]    cnt, cnt_n, base_cnt;
    logic             dup, dup_n, base_dup;
    logic             oor, oor_n, base_oor;
    logic [IDX_W-1:0] pos;
    logic             in_range, accept, fresh;

`ifdef IDX_TO_VEC_OVERLAP_EN
    assign idx_ready_o = (state == ACCUM) | vec_ready_i;
`else
    assign idx_ready_o = (state == ACCUM);
`endif

    assign accept      = idx_valid_i & idx_ready_o;
    assign fresh       = (state == HOLD) & vec_ready_i;
    assign in_range    = ({1'b0, idx_i} < LIMIT);
    assign pos         = MODE ? (TOP - idx_i) : idx_i;

    assign vec_o       = acc;
    assign cnt_o       = cnt;
    assign dup_o       = dup;
    assign oor_o       = oor;
    assign vec_valid_o = (state == HOLD);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            onehot[i] = (pos == IDX_W'(i));
        end
    end

    // A handshake clears the accumulator; a beat taken in the same cycle builds on the cleared value.
    always_comb begin
        base_acc = fresh ? '0   : acc;
        base_cnt = fresh ? '0   : cnt;
        base_dup = fresh ? 1'b0 : dup;
        base_oor = fresh ? 1'b0 : oor;
        acc_n    = base_acc;
        cnt_n    = base_cnt;
        dup_n    = base_dup;
        oor_n    = base_oor;
        state_n  = fresh ? ACCUM : state;
        if (accept) begin
            if (!idx_empty_i) begin
                if (!in_range) begin
                    oor_n = 1'b1;
                end else if (|(base_acc & onehot)) begin
                    dup_n = 1'b1;
                end else begin
                    acc_n = base_acc | onehot;
                    cnt_n = base_cnt + CW'(1);
                end
            end
            if (idx_last_i) begin
                state_n = HOLD;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            dup   <= 1'b0;
            oor   <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            dup   <= dup_n;
            oor   <= oor_n;
        end
    end

`ifndef SYNTHESIS
    width_positive : assert property (@(posedge clk_i) WIDTH > 0);
`endif

endmodule

// File: tb/tb_idx_to_vec.sv
// Directed bench: three instances (W8/LSB, W8/MSB, W6/LSB) share one beat stream.
module tb_idx_to_vec;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] idx = '0;
    logic       empty = 1'b0;
    logic       last = 1'b0;
    logic       valid = 1'b0;
    logic       vrdy = 1'b0;

    logic [7:0] vec_a, vec_b;
    logic [5:0] vec_c;
    logic [3:0] cnt_a, cnt_b;
    logic [2:0] cnt_c;
    logic       dup_a, dup_b, dup_c, oor_a, oor_b, oor_c;
    logic       vv_a, vv_b, vv_c, rdy_a, rdy_b, rdy_c;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    idx_to_vec #(.WIDTH(8), .MODE(1'b0)) u_a (
        .clk_i(clk), .rst_i(rst), .idx_i(idx), .idx_empty_i(empty), .idx_last_i(last),
        .idx_valid_i(valid), .idx_ready_o(rdy_a), .vec_o(vec_a), .cnt_o(cnt_a),
        .dup_o(dup_a), .oor_o(oor_a), .vec_valid_o(vv_a), .vec_ready_i(vrdy));

    idx_to_vec #(.WIDTH(8), .MODE(1'b1)) u_b (
        .clk_i(clk), .rst_i(rst), .idx_i(idx), .idx_empty_i(empty), .idx_last_i(last),
        .idx_valid_i(valid), .idx_ready_o(rdy_b), .vec_o(vec_b), .cnt_o(cnt_b),
        .dup_o(dup_b), .oor_o(oor_b), .vec_valid_o(vv_b), .vec_ready_i(vrdy));

    idx_to_vec #(.WIDTH(6), .MODE(1'b0)) u_c (
        .clk_i(clk), .rst_i(rst), .idx_i(idx), .idx_empty_i(empty), .idx_last_i(last),
        .idx_valid_i(valid), .idx_ready_o(rdy_c), .vec_o(vec_c), .cnt_o(cnt_c),
        .dup_o(dup_c), .oor_o(oor_c), .vec_valid_o(vv_c), .vec_ready_i(vrdy));

    // Called at a negedge while the DUTs are in ACCUM; returns at the next negedge.
    task automatic beat(input logic [2:0] i, input logic e, input logic l);
        idx = i; empty = e; last = l; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0; empty = 1'b0; last = 1'b0;
    endtask

    task automatic drain();
        vrdy = 1'b1;
        @(negedge clk);
        vrdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if ({vec_a, cnt_a, dup_a, oor_a, vv_a} !== 15'h0) begin n_fail++; $display("FAIL reset_outs_a: got %h want 0", {vec_a, cnt_a, dup_a, oor_a, vv_a}); end
        n_checks++; if ({vec_c, cnt_c, oor_c, vv_c} !== 11'h0) begin n_fail++; $display("FAIL reset_outs_c: got %h want 0", {vec_c, cnt_c, oor_c, vv_c}); end
        n_checks++; if ({rdy_a, rdy_b, rdy_c} !== 3'b111) begin n_fail++; $display("FAIL reset_ready: got %b want 111", {rdy_a, rdy_b, rdy_c}); end
    endtask

    task automatic test_hold();
        beat(3'd0, 1'b0, 1'b0);
        beat(3'd3, 1'b0, 1'b0);
        beat(3'd7, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (vv_a !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b want 1", k, vv_a); end
            n_checks++; if (vec_a !== 8'h89 || cnt_a !== 4'd3) begin n_fail++; $display("FAIL hold_vec[%0d]: got %h/%0d want 89/3", k, vec_a, cnt_a); end
            n_checks++; if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL hold_ready[%0d]: got %b want 0", k, rdy_a); end
            @(negedge clk);
        end
        n_checks++; if (vec_b !== 8'h91 || cnt_b !== 4'd3) begin n_fail++; $display("FAIL hold_msb: got %h/%0d want 91/3", vec_b, cnt_b); end
        n_checks++; if (vec_c !== 6'h09 || cnt_c !== 3'd2 || oor_c !== 1'b1) begin n_fail++; $display("FAIL hold_w6: got %h/%0d/%b want 09/2/1", vec_c, cnt_c, oor_c); end
        drain();
        n_checks++; if (vv_a !== 1'b0 || rdy_a !== 1'b1) begin n_fail++; $display("FAIL hold_release: got vv=%b rdy=%b want 0/1", vv_a, rdy_a); end
        n_checks++; if (vec_a !== 8'h00 || cnt_a !== 4'd0) begin n_fail++; $display("FAIL hold_clear: got %h/%0d want 00/0", vec_a, cnt_a); end
    endtask

    task automatic test_mode1();
        beat(3'd0, 1'b0, 1'b0);
        beat(3'd3, 1'b0, 1'b1);
        n_checks++; if (vv_b !== 1'b1 || vec_b !== 8'h90 || cnt_b !== 4'd2 || dup_b !== 1'b0) begin n_fail++; $display("FAIL mode1: got vv=%b %h/%0d dup=%b want 1 90/2 0", vv_b, vec_b, cnt_b, dup_b); end
        n_checks++; if (vec_a !== 8'h09) begin n_fail++; $display("FAIL mode0_same: got %h want 09", vec_a); end
        drain();
    endtask

    task automatic test_dup();
        beat(3'd5, 1'b0, 1'b0);
        beat(3'd5, 1'b0, 1'b1);
        n_checks++; if (vec_a !== 8'h20 || cnt_a !== 4'd1 || dup_a !== 1'b1) begin n_fail++; $display("FAIL dup: got %h/%0d dup=%b want 20/1 1", vec_a, cnt_a, dup_a); end
        drain();
        beat(3'd2, 1'b0, 1'b1);
        n_checks++; if (vec_a !== 8'h04 || cnt_a !== 4'd1 || dup_a !== 1'b0) begin n_fail++; $display("FAIL dup_cleared: got %h/%0d dup=%b want 04/1 0", vec_a, cnt_a, dup_a); end
        drain();
    endtask

    task automatic test_oor();
        beat(3'd6, 1'b0, 1'b0);
        beat(3'd0, 1'b1, 1'b1);
        n_checks++; if (vv_c !== 1'b1 || vec_c !== 6'h00 || cnt_c !== 3'd0 || oor_c !== 1'b1) begin n_fail++; $display("FAIL oor: got vv=%b %h/%0d oor=%b want 1 00/0 1", vv_c, vec_c, cnt_c, oor_c); end
        n_checks++; if (vec_a !== 8'h40 || oor_a !== 1'b0) begin n_fail++; $display("FAIL oor_w8: got %h oor=%b want 40 0", vec_a, oor_a); end
        drain();
        beat(3'd0, 1'b1, 1'b1);
        n_checks++; if (vv_a !== 1'b1 || vec_a !== 8'h00 || cnt_a !== 4'd0) begin n_fail++; $display("FAIL empty_vec: got vv=%b %h/%0d want 1 00/0", vv_a, vec_a, cnt_a); end
        drain();
    endtask

    task automatic test_reset_mid();
        beat(3'd4, 1'b0, 1'b0);
        beat(3'd5, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (vv_a !== 1'b0 || vec_a !== 8'h00 || rdy_a !== 1'b1) begin n_fail++; $display("FAIL reset_mid: got vv=%b %h rdy=%b want 0 00 1", vv_a, vec_a, rdy_a); end
        beat(3'd1, 1'b0, 1'b1);
        n_checks++; if (vv_a !== 1'b1 || vec_a !== 8'h02 || cnt_a !== 4'd1) begin n_fail++; $display("FAIL after_reset: got vv=%b %h/%0d want 1 02/1", vv_a, vec_a, cnt_a); end
        drain();
    endtask

    task automatic test_back_to_back();
        vrdy = 1'b1;
        idx = 3'd1; last = 1'b1; valid = 1'b1;
        @(negedge clk);
        n_checks++; if (vv_a !== 1'b1 || vec_a !== 8'h02) begin n_fail++; $display("FAIL b2b_first: got vv=%b %h want 1 02", vv_a, vec_a); end
        idx = 3'd2;
        @(negedge clk);
`ifdef IDX_TO_VEC_OVERLAP_EN
        n_checks++; if (vv_a !== 1'b1 || vec_a !== 8'h04) begin n_fail++; $display("FAIL b2b_second: got vv=%b %h want 1 04", vv_a, vec_a); end
        idx = 3'd3;
        @(negedge clk);
        n_checks++; if (vv_a !== 1'b1 || vec_a !== 8'h08) begin n_fail++; $display("FAIL b2b_third: got vv=%b %h want 1 08", vv_a, vec_a); end
        valid = 1'b0; last = 1'b0;
        @(negedge clk);
        n_checks++; if (vv_a !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got vv=%b want 0", vv_a); end
`else
        n_checks++; if (vv_a !== 1'b0 || rdy_a !== 1'b1) begin n_fail++; $display("FAIL b2b_bubble: got vv=%b rdy=%b want 0 1", vv_a, rdy_a); end
        @(negedge clk);
        n_checks++; if (vv_a !== 1'b1 || vec_a !== 8'h04) begin n_fail++; $display("FAIL b2b_second: got vv=%b %h want 1 04", vv_a, vec_a); end
        valid = 1'b0; last = 1'b0;
        @(negedge clk);
        n_checks++; if (vv_a !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got vv=%b want 0", vv_a); end
`endif
        vrdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hold();
        test_mode1();
        test_dup();
        test_oor();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/idx_to_vec.md
Name: idx_to_vec

Overview:
- Streaming index-to-vector assembler; inverse of the leading/trailing zero counter.
- Accepts a stream of bit indices over valid/ready, one index per beat, terminated by a last flag.
- Rebuilds the bit vector those indices describe and emits it as one registered valid/ready transaction.
- Used on the receive side of paths where a vector is serialised as a stream of set-bit positions (e.g. iterated first-one extraction).

Parameters:
- WIDTH, 32, output vector width; WIDTH >= 1.
- MODE, 1'b0, index convention: 0 = index counted from LSB (bit idx); 1 = index counted from MSB (bit WIDTH-1-idx).
- IDX_W, (WIDTH > 1) ? $clog2(WIDTH) : 1, index width; derived, not overridden.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous reset, active-high
- idx_i  input  IDX_W  bit index carried by the beat
- idx_empty_i  input  1  beat carries no index; idx_i is ignored
- idx_last_i  input  1  final beat of the current vector
- idx_valid_i  input  1  input beat valid
- idx_ready_o  output  1  input beat accepted when valid & ready
- vec_o  output  WIDTH  assembled vector
- cnt_o  output  $clog2(WIDTH+1)  number of set bits in vec_o
- dup_o  output  1  some index in the vector was received more than once
- oor_o  output  1  some index in the vector was >= WIDTH
- vec_valid_o  output  1  vector transaction valid
- vec_ready_i  input  1  vector accepted when valid & ready

Behaviour:
- One clock (clk_i), synchronous active-high reset (rst_i).
- Reset values: state ACCUM, accumulator 0, vec_o 0, cnt_o 0, dup_o 0, oor_o 0, vec_valid_o 0. idx_ready_o is 1 in the first cycle after reset.
- States:
  - ACCUM: idx_ready_o = 1.
  - HOLD: idx_ready_o = 0; vec_valid_o = 1.
- idx_ready_o depends on state only. It never depends on idx_valid_i.
- Beat accepted (idx_valid_i & idx_ready_o):
  - idx_empty_i = 1: no bit is set.
  - else if idx_i >= WIDTH: oor sticky-set; no bit is set.
  - else: p = MODE ? WIDTH-1-idx_i : idx_i.
    - acc[p] already 1: dup sticky-set; cnt unchanged.
    - otherwise: acc[p] is set and cnt increments.
  - idx_last_i = 1: go to HOLD. The beat's own contribution is included.
- Latency: last beat accepted in cycle t, vec_valid_o = 1 in cycle t+1. Base throughput is N beats + 1 cycle per vector.
- vec_o, cnt_o, dup_o and oor_o are driven directly from the accumulator registers. They are meaningful only while vec_valid_o = 1, and stay stable throughout HOLD.
- HOLD with vec_ready_i = 1: accumulator, cnt and flags clear. State returns to ACCUM, so vec_valid_o = 0 next cycle.
- Once asserted, vec_valid_o holds until the handshake. It is never withdrawn except by reset.
- An empty vector (single empty+last beat) is a legal transaction: vec_o = 0, cnt_o = 0.
- cnt_o cannot overflow: at most WIDTH distinct bits can be set.
- Reset mid-vector: the partial vector is discarded and vec_valid_o = 0 next cycle. A pending HOLD is dropped without a handshake.
- Simulation-only assertion: WIDTH > 0.

Optional Feature:
- Macro: IDX_TO_VEC_OVERLAP_EN.
- Defined:
  - In HOLD, idx_ready_o = vec_ready_i.
  - A beat accepted in the vector-handshake cycle initialises the accumulator with only its own contribution; flags and cnt start fresh from that beat.
  - If that beat is also last, state stays HOLD and vec_valid_o stays 1 with the new vector next cycle.
  - Back-to-back single-beat vectors sustain 1 vector/cycle.
- Not defined:
  - idx_ready_o = 0 throughout HOLD.
  - One bubble cycle between vectors.

Test Plan:
- Reset: hold rst_i 2 cycles -> all outputs 0, idx_ready_o = 1 in the cycle after release.
- WIDTH=8, MODE=0, beats idx 0, 3, 7(last) with vec_ready_i = 0 for 3 cycles -> vec_valid_o rises the cycle after the last beat; vec_o = 8'h89, cnt_o = 3 stable for all 3 cycles; idx_ready_o = 0 during HOLD; ACCUM resumes after vec_ready_i = 1.
- WIDTH=8, MODE=1, beats 0, 3(last) -> vec_o = 8'h90, cnt_o = 2, dup_o = 0.
- WIDTH=8, beats 5, 5(last) -> vec_o = 8'h20, cnt_o = 1, dup_o = 1; a following vector with beat 2(last) -> vec_o = 8'h04, dup_o = 0.
- WIDTH=6, beat idx 6 then empty+last -> vec_o = 0, cnt_o = 0, oor_o = 1.
- Reset asserted after 2 accepted beats -> no vec_valid_o; next vector with beat 1(last) -> vec_o = 8'h02 only.
- With IDX_TO_VEC_OVERLAP_EN, vec_ready_i tied 1 and single-beat last vectors 1, 2, 3 -> vec_valid_o stays 1 for 3 consecutive cycles with vec_o 8'h02, 8'h04, 8'h08.
